// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Two-port round-robin arbiter that shares the single Avalon-MM
//               master port of mips_cpu_bus between instruction fetch (I)
//               and load/store (D). One transfer is in flight at a time.
//               The winning command is latched, run on the bus, and then
//               acknowledged back to its owner with read data.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset                 : clock; asynchronous active-high reset
//   i_req/i_addr               : fetch request and byte address
//   i_ack/i_rdata              : fetch completion pulse and held fetch word
//   d_req/d_write/d_addr/
//   d_wdata/d_byteenable       : load/store request and command
//   d_ack/d_rdata              : data completion pulse and held load word
//   address/read/write/
//   writedata/byteenable       : Avalon master command outputs
//   waitrequest/readdata       : Avalon slave stall and read data
// ============================================================================
module mips_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Port identity used for both `owner` and `last`.
    localparam logic c_port_i = 1'b0;
    localparam logic c_port_d = 1'b1;

    state_t      state_q,   state_d;
    logic        owner_q,   owner_d;
    logic        last_q,    last_d;
    logic [31:0] addr_q,    addr_d;
    logic        wr_q,      wr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  be_q,      be_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        w_grant_d;
    logic        w_in_bus;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= c_port_i;
            // Pretend D was served last so I wins the first conflict.
            last_q    <= c_port_d;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        // On a conflict the port that was not served last wins.
        w_grant_d = (i_req && d_req) ? (last_q == c_port_i) : d_req;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = w_grant_d;
                    state_d = ST_BUS;
                    if (w_grant_d == c_port_d) begin
                        addr_d  = d_addr;
                        wr_d    = d_write;
                        wdata_d = d_wdata;
                        be_d    = d_byteenable;
                    end else begin
                        addr_d  = i_addr;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = 4'b1111;
                    end
                end
            end
            ST_BUS: begin
                if (!waitrequest) begin
                    if (!wr_q) begin
                        if (owner_q == c_port_d) begin
                            d_rdata_d = readdata;
                        end else begin
                            i_rdata_d = readdata;
                        end
                    end
                    last_d  = owner_q;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from registered state only; zero outside BUS.
    assign w_in_bus   = (state_q == ST_BUS);
    assign read       = w_in_bus && !wr_q;
    assign write      = w_in_bus && wr_q;
    assign address    = w_in_bus ? addr_q  : 32'h0;
    assign writedata  = w_in_bus ? wdata_q : 32'h0;
    assign byteenable = w_in_bus ? be_q    : 4'h0;

    assign i_ack   = (state_q == ST_ACK) && (owner_q == c_port_i);
    assign d_ack   = (state_q == ST_ACK) && (owner_q == c_port_d);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Directed self-checking bench for mips_bus_arbiter. Inputs are
//               driven and outputs sampled 1 time unit after each rising edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int errors = 0;
    int checks = 0;

    mips_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_byteenable (d_byteenable),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdata     (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, ".read"},  {31'd0, read},  32'd0);
        chk({tag, ".write"}, {31'd0, write}, 32'd0);
        chk({tag, ".addr"},  address,        32'd0);
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; d_byteenable = '0; waitrequest = 1'b0; readdata = '0;

        // ---------------- reset values ----------------
        step(); step();
        chk_idle_bus("rst");
        chk("rst.wdata", writedata, 32'd0);
        chk("rst.be", {28'd0, byteenable}, 32'd0);
        chk("rst.acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst.i_rdata", i_rdata, 32'd0);
        chk("rst.d_rdata", d_rdata, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("quiet.strobes", {30'd0, read, write}, 32'd0);
            chk("quiet.acks", {30'd0, i_ack, d_ack}, 32'd0);
        end

        // ---------------- single fetch, zero wait ----------------
        i_req = 1'b1; i_addr = 32'hBFC0_0000; readdata = 32'h0000_0021;  // cycle T
        step();                                                            // T+1
        chk("f.read", {31'd0, read}, 32'd1);
        chk("f.write", {31'd0, write}, 32'd0);
        chk("f.addr", address, 32'hBFC0_0000);
        chk("f.be", {28'd0, byteenable}, 32'hF);
        chk("f.early_ack", {31'd0, i_ack}, 32'd0);
        step();                                                            // T+2
        chk("f.i_ack", {31'd0, i_ack}, 32'd1);
        chk("f.d_ack", {31'd0, d_ack}, 32'd0);
        chk("f.i_rdata", i_rdata, 32'h21);
        chk("f.ack_read", {31'd0, read}, 32'd0);
        i_req = 1'b0;
        step();                                                            // T+3
        chk("f.ack_pulse", {31'd0, i_ack}, 32'd0);
        chk_idle_bus("f.idle");

        // ---------------- load with 3 wait cycles ----------------
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_1000; d_byteenable = 4'b1111;
        waitrequest = 1'b1; readdata = 32'h5555_5555;                      // T
        for (int k = 1; k <= 3; k++) begin
            step();                                                        // T+1..T+3
            chk("w.read", {31'd0, read}, 32'd1);
            chk("w.addr", address, 32'h0000_1000);
            chk("w.be", {28'd0, byteenable}, 32'hF);
            chk("w.ack", {30'd0, i_ack, d_ack}, 32'd0);
            d_addr = 32'hFFFF_0000;  // ignored while owned
        end
        step();                                                            // T+4
        chk("w.read4", {31'd0, read}, 32'd1);
        chk("w.addr4", address, 32'h0000_1000);
        waitrequest = 1'b0; readdata = 32'hCAFE_F00D;
        step();                                                            // T+5
        chk("w.d_ack", {31'd0, d_ack}, 32'd1);
        chk("w.i_ack", {31'd0, i_ack}, 32'd0);
        chk("w.d_rdata", d_rdata, 32'hCAFE_F00D);
        chk("w.i_rdata", i_rdata, 32'h21);
        d_req = 1'b0;
        step();                                                            // IDLE

        // ---------------- store ----------------
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_2004; d_wdata = 32'hDEAD_BEEF;
        d_byteenable = 4'b0011; readdata = 32'h1234_5678;                  // T
        step();                                                            // T+1
        chk("s.write", {31'd0, write}, 32'd1);
        chk("s.read", {31'd0, read}, 32'd0);
        chk("s.addr", address, 32'h0000_2004);
        chk("s.wdata", writedata, 32'hDEAD_BEEF);
        chk("s.be", {28'd0, byteenable}, 32'h3);
        step();                                                            // T+2
        chk("s.d_ack", {31'd0, d_ack}, 32'd1);
        chk("s.d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0; d_write = 1'b0;
        step();
        chk("s.ack_pulse", {31'd0, d_ack}, 32'd0);
        chk("s.wdata_idle", writedata, 32'd0);

        // ---------------- conflict and round-robin from reset ----------------
        reset = 1'b1;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0200; d_byteenable = 4'b1111;
        readdata = 32'hAAAA_0001; waitrequest = 1'b0;
        step();
        chk("c.rst_d_rdata", d_rdata, 32'd0);
        chk("c.rst_i_rdata", i_rdata, 32'd0);
        reset = 1'b0;                                                      // T (IDLE)
        step();
        chk("c1.addr_i", address, 32'h0000_0100);
        chk("c1.read", {31'd0, read}, 32'd1);
        step();
        chk("c1.i_ack", {31'd0, i_ack}, 32'd1);
        chk("c1.d_ack", {31'd0, d_ack}, 32'd0);
        chk("c1.i_rdata", i_rdata, 32'hAAAA_0001);
        i_req = 1'b0; readdata = 32'hBBBB_0002;
        step();                                                            // IDLE, D pending
        step();
        chk("c2.addr_d", address, 32'h0000_0200);
        step();
        chk("c2.d_ack", {31'd0, d_ack}, 32'd1);
        chk("c2.d_rdata", d_rdata, 32'hBBBB_0002);
        chk("c2.i_rdata", i_rdata, 32'hAAAA_0001);
        i_req = 1'b1;                                                      // both again
        step();
        chk_idle_bus("c3.idle");
        step();
        chk("c3.addr_i", address, 32'h0000_0100);
        step();
        chk("c3.i_ack", {31'd0, i_ack}, 32'd1);
        i_req = 1'b0;
        step();
        step();
        chk("c4.addr_d", address, 32'h0000_0200);
        step();
        chk("c4.d_ack", {31'd0, d_ack}, 32'd1);
        d_req = 1'b0;
        step();
        // lone D transfer, then a conflict must go to I
        d_req = 1'b1; d_addr = 32'h0000_0300;
        step();
        chk("c5.addr_d", address, 32'h0000_0300);
        step();
        chk("c5.d_ack", {31'd0, d_ack}, 32'd1);
        i_req = 1'b1;
        step();
        step();
        chk("c6.addr_i", address, 32'h0000_0100);
        step();
        chk("c6.i_ack", {31'd0, i_ack}, 32'd1);
        i_req = 1'b0; d_req = 1'b0;
        step(); step(); step();

        // ---------------- reset mid-transfer ----------------
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0400; waitrequest = 1'b1;
        step();
        chk("r.read_before", {31'd0, read}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_idle_bus("r.async");
        step();
        chk("r.no_ack", {30'd0, i_ack, d_ack}, 32'd0);
        chk("r.d_rdata", d_rdata, 32'd0);
        waitrequest = 1'b0; readdata = 32'h0000_0077;
        reset = 1'b0;
        step();
        chk("r.read_after", {31'd0, read}, 32'd1);
        chk("r.addr_after", address, 32'h0000_0400);
        step();
        chk("r.d_ack", {31'd0, d_ack}, 32'd1);
        chk("r.d_rdata_after", d_rdata, 32'h0000_0077);
        d_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-port arbiter sharing the single Avalon memory-mapped master port of `mips_cpu_bus` between the instruction-fetch side and the load/store side of the core. It accepts one request at a time from each port and chooses between simultaneous requests by round-robin. The granted request runs as one Avalon transfer, and the arbiter returns completion with read data to the winning port. It sits between the CPU state machine and the top-level bus pins.

## Interface
No parameters (bus widths fixed at 32-bit address/data, 4-bit byteenable).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_req  in  1  fetch request; held high and stable until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  32  fetched word; holds until next i_ack
- d_req  in  1  data request; held high and stable until d_ack
- d_write  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_byteenable  in  4  store/load lane enables
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load word; updated only on load completion
- address  out  32  Avalon address
- read  out  1  Avalon read strobe
- write  out  1  Avalon write strobe
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon byte enables
- waitrequest  in  1  Avalon slave stall
- readdata  in  32  Avalon read data, valid in the cycle waitrequest is low

## Operation
- FSM states: IDLE, BUS, ACK. Register `owner` (I or D) and `last` (last port served).
- IDLE: if only one port requests, grant it. If both request, grant the port that is not `last`. If neither requests, stay in IDLE. On grant, latch the owner's address, command, wdata and byteenable into bus registers, then go to BUS.
- BUS: drive the latched command. Fetch: read=1, write=0, byteenable=4'b1111. Data: read=!d_write, write=d_write, with the latched writedata and byteenable.
  - Stay in BUS while waitrequest=1. All bus outputs hold constant.
  - On the edge where waitrequest=0: for a read, capture readdata into the owner's rdata register; set `last`=owner; go to ACK.
- ACK: pulse owner's ack for this cycle only; read and write are 0; go to IDLE.
- Outside BUS: read=0, write=0, address/writedata/byteenable=0.
- Stores never modify d_rdata. i_rdata and d_rdata are independent holding registers.
- Requester inputs are sampled only in IDLE. Changes to a requester's inputs while it is pending or owned are ignored, because the command is latched.
- A request that loses arbitration stays pending. It is guaranteed the next grant, so starvation is bounded to one transfer.
- Address is passed through unmodified (byte address). Alignment is the requester's responsibility.

## Timing
- Reset (asynchronous, mid-transfer included): state=IDLE, `last`=D (so I wins the first conflict). The following outputs are 0: read, write, address, writedata, byteenable, i_ack, d_ack, i_rdata, d_rdata. A transfer in progress is abandoned with no ack.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Zero-wait transfer: req high in cycle T (IDLE), strobe in T+1 (BUS, waitrequest=0), ack in T+2, IDLE in T+3.
  - Req-to-ack = 2 + N cycles, where N is the number of waitrequest-high cycles.
  - Back-to-back throughput: one transfer per 3 cycles.
- Requester must drop req, or present a new request, by the cycle after ack. Req still high in the IDLE following its ack is treated as a new request.
- Simultaneous req from both ports in IDLE: exactly one is granted. The other gets read/write in the cycle after the first's ACK+IDLE sequence.

## Test plan
- Reset values: hold reset, then release. Check all outputs are 0 and no strobe appears with both req low for 10 cycles.
- Single fetch, zero wait: i_req, i_addr=32'hBFC0_0000, readdata=32'h0000_0021.
  - Expect read=1 and address=BFC00000 one cycle later.
  - Expect i_ack pulse with i_rdata=32'h21 at T+2, and d_ack never asserted.
- Wait stretch: data load at 32'h1000 with waitrequest high for 3 cycles.
  - Expect address, read and byteenable stable throughout.
  - Expect d_ack at T+5 with d_rdata=readdata; i_rdata unchanged.
- Store: d_write=1, d_addr=32'h2004, d_wdata=32'hDEAD_BEEF, d_byteenable=4'b0011.
  - Expect write=1 with those values and read=0.
  - Expect d_ack, and d_rdata unchanged from its prior value.
- Conflict and round-robin: both req high from reset.
  - Expect I served first, then D. Re-request both: expect I, D order again.
  - After a lone D transfer, a conflict grants I.
- Reset mid-transfer: assert reset during BUS with waitrequest=1.
  - Expect read and write to go to 0 asynchronously, the same cycle, with no ack.
  - After release, a new request completes normally.
